// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the single-port IO register block between two masters
// (M0 = CPU data port, M1 = debug/loader). Each access latches the winner's request,
// drives the slave for one access window (plus WAIT_CYC wait cycles), captures RD and
// returns it with a one-cycle ack pulse.
// Build option: define IO_ARB_RR_EN for round-robin arbitration; otherwise M0 has
// fixed priority over M1.
module io_bus_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 3,
  parameter int WAIT_CYC = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [3:0]    m0_be,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [3:0]    m1_be,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_ack,
  output logic          m1_ack,
  output logic [DW-1:0] rdata,
  output logic [1:0]    gnt,
  output logic [3:0]    s_byteEn,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wd,
  input  logic [DW-1:0] s_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Owner encoding: 0 = M0, 1 = M1.
  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  state_t      state;
  logic        owner;
  logic        lat_we;
  logic [3:0]  lat_be;
  logic [3:0]  cnt;

`ifdef IO_ARB_RR_EN
  logic        last_owner;
`endif

  // Arbitration result for the next grant (only acted on in IDLE and ACK).
  logic          cand0;
  logic          cand1;
  logic          arb_valid;
  logic          arb_sel;
  logic          sel_we;
  logic [3:0]    sel_be;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Pick the next owner; in ACK the current owner's still-high req is masked out.
  always_comb begin
    cand0 = m0_req;
    cand1 = m1_req;
    if (state == ACK) begin
      cand0 = m0_req && (owner == OWN_M1);
      cand1 = m1_req && (owner == OWN_M0);
    end
`ifdef IO_ARB_RR_EN
    // On a tie the master that did not own the bus last time wins.
    arb_sel   = cand1 && (!cand0 || (last_owner == OWN_M0));
    arb_valid = cand0 || cand1;
`else
    // M0 always has priority: M1 only wins while M0 is not requesting at all,
    // so M1 cannot slip in behind an M0 ack while M0 keeps its req up.
    arb_sel   = cand1 && !m0_req;
    arb_valid = cand0 || arb_sel;
`endif
    sel_we    = arb_sel ? m1_we    : m0_we;
    sel_be    = arb_sel ? m1_be    : m0_be;
    sel_addr  = arb_sel ? m1_addr  : m0_addr;
    sel_wdata = arb_sel ? m1_wdata : m0_wdata;
  end

  // Access FSM; every output is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= OWN_M0;
      lat_we   <= 1'b0;
      lat_be   <= '0;
      cnt      <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      rdata    <= '0;
      gnt      <= '0;
      s_byteEn <= '0;
      s_addr   <= '0;
      s_wd     <= '0;
`ifdef IO_ARB_RR_EN
      last_owner <= OWN_M1;
`endif
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE, ACK: begin
          gnt      <= '0;
          s_byteEn <= '0;
          if (arb_valid) begin
            // s_addr/s_wd are the latched copies of the winner's address and data;
            // they then hold through BUSY and beyond.
            state  <= BUSY;
            owner  <= arb_sel;
            gnt    <= arb_sel ? 2'b10 : 2'b01;
            lat_we <= sel_we;
            lat_be <= sel_be;
            s_addr <= sel_addr;
            s_wd   <= sel_wdata;
            cnt    <= WAIT_INIT;
            // With no wait cycles the first BUSY cycle is also the commit cycle.
            s_byteEn <= (WAIT_CYC == 0 && sel_we) ? sel_be : 4'b0000;
`ifdef IO_ARB_RR_EN
            last_owner <= arb_sel;
`endif
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            // Enables appear only in the last BUSY cycle, so a write commits once.
            s_byteEn <= (cnt == 4'd1 && lat_we) ? lat_be : 4'b0000;
          end else begin
            rdata    <= s_rd;
            state    <= ACK;
            gnt      <= '0;
            s_byteEn <= '0;
            m0_ack   <= (owner == OWN_M0);
            m1_ack   <= (owner == OWN_M1);
          end
        end
        default: begin
          state    <= IDLE;
          gnt      <= '0;
          s_byteEn <= '0;
        end
      endcase
    end
  end

endmodule
